// File: rtl/demux_rr.sv
// Round-robin demultiplexer: spreads one valid/ready word stream across LANES
// registered output lanes in strict rotation. Define DEMUX_RR_IDLE_REALIGN_EN to
// restart every burst on lane 0 after an idle cycle.
module demux_rr #(
  parameter int DATA_W = 8,
  parameter int LANES  = 2,
  parameter int PTR_W  = $clog2(LANES),
  parameter int CNT_W  = 16
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [LANES*DATA_W-1:0] data_out,
  output logic [LANES-1:0]        valid_out,
  input  logic [LANES-1:0]        ready_in,
  output logic [PTR_W-1:0]        lane_ptr,
  output logic [CNT_W-1:0]        word_cnt
);

  logic [DATA_W-1:0] lane_q [LANES];
  logic [LANES-1:0]  valid_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_next;
  logic [CNT_W-1:0]  cnt_q;
  logic              acc;

  // The target lane can take a word if it is empty or being drained this cycle.
  assign ready_out = ~reset & (~valid_q[ptr_q] | ready_in[ptr_q]);
  assign acc       = valid_in & ready_out;
  assign ptr_next  = (ptr_q == PTR_W'(LANES - 1)) ? '0 : ptr_q + PTR_W'(1);

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      // NOTE: the lane data registers are reset too, because data_out must read
      // zero after reset; a plain storage array would normally be left unreset.
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (valid_q[k] & ready_in[k]) valid_q[k] <= 1'b0;
      end
      if (acc) begin
        // NOTE: this non-blocking write comes after the drain loop, so when a lane
        // drains and loads on the same edge the later assignment (the load) wins.
        lane_q[ptr_q]  <= data_in;
        valid_q[ptr_q] <= 1'b1;
        ptr_q          <= ptr_next;
        cnt_q          <= cnt_q + CNT_W'(1);
      end
`ifdef DEMUX_RR_IDLE_REALIGN_EN
      else if (!valid_in) begin
        ptr_q <= '0;
      end
`endif
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign data_out[k*DATA_W +: DATA_W] = lane_q[k];
  end

  assign valid_out = valid_q;
  assign lane_ptr  = ptr_q;
  assign word_cnt  = cnt_q;

endmodule
